result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/result_display.sv
// ============================================================================
//  Module   : result_display
//  Brief    : Captures a finished test result, converts it to BCD with a
//             sequential double-dabble, and scans it onto a 4-digit 7-seg.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module result_display #(
   parameter int REFRESH_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] result,
   input  logic [3:0] number_of_testing,
   input  logic       busy,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       conv_busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         DIV_W  = $clog2(REFRESH_DIV);
   localparam logic [6:0] C_DASH  = 7'b0111111;
   localparam logic [6:0] C_BLANK = 7'b1111111;

   logic [1:0]       state_q, state_d;
   logic             busy_q;
   logic [7:0]       bin_q, bin_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [11:0]      bcd_q, bcd_d;
   logic [2:0]       bit_q, bit_d;
   logic             pend_q, pend_d;
   logic [7:0]       pend_res_q, pend_res_d;
   logic [3:0]       pend_cnt_q, pend_cnt_d;
   logic [11:0]      disp_bcd_q, disp_bcd_d;
   logic [3:0]       disp_cnt_q, disp_cnt_d;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       idx_q;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic             w_capture;
   logic [11:0]      w_adj;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   assign w_capture = busy_q & ~busy;
   assign w_adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
   assign conv_busy = (state_q != S_IDLE);
   assign seg       = seg_q;
   assign an        = an_q;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      bit_d      = bit_q;
      pend_d     = pend_q;
      pend_res_d = pend_res_q;
      pend_cnt_d = pend_cnt_q;
      disp_bcd_d = disp_bcd_q;
      disp_cnt_d = disp_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_capture) begin
               bin_d   = result;
               cnt_d   = number_of_testing;
               bcd_d   = 12'd0;
               bit_d   = 3'd0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            {bcd_d, bin_d} = {w_adj, bin_q} << 1;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_DONE;
            if (w_capture) begin
               pend_d     = 1'b1;
               pend_res_d = result;
               pend_cnt_d = number_of_testing;
            end
         end
         S_DONE: begin
            disp_bcd_d = bcd_q;
            disp_cnt_d = cnt_q;
            pend_d     = 1'b0;
            bcd_d      = 12'd0;
            bit_d      = 3'd0;
            // A capture landing in DONE is newer than anything pending.
            if (w_capture) begin
               bin_d   = result;
               cnt_d   = number_of_testing;
               state_d = S_CONV;
            end else if (pend_q) begin
               bin_d   = pend_res_q;
               cnt_d   = pend_cnt_q;
               state_d = S_CONV;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      seg_d = C_BLANK;
      an_d  = ~(4'b0001 << idx_q);
      case (idx_q)
         2'd0: seg_d = busy ? C_DASH : enc(disp_bcd_q[3:0]);
         2'd1: seg_d = busy ? C_DASH :
                       (disp_bcd_q[11:4] == 8'd0) ? C_BLANK : enc(disp_bcd_q[7:4]);
         2'd2: seg_d = busy ? C_DASH :
                       (disp_bcd_q[11:8] == 4'd0) ? C_BLANK : enc(disp_bcd_q[11:8]);
         default: seg_d = enc(disp_cnt_q);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         bin_q      <= 8'd0;
         cnt_q      <= 4'd0;
         bcd_q      <= 12'd0;
         bit_q      <= 3'd0;
         pend_q     <= 1'b0;
         pend_res_q <= 8'd0;
         pend_cnt_q <= 4'd0;
         disp_bcd_q <= 12'd0;
         disp_cnt_q <= 4'd0;
         div_q      <= '0;
         idx_q      <= 2'd0;
         seg_q      <= 7'b1000000;
         an_q       <= 4'b1110;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy;
         bin_q      <= bin_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         bit_q      <= bit_d;
         pend_q     <= pend_d;
         pend_res_q <= pend_res_d;
         pend_cnt_q <= pend_cnt_d;
         disp_bcd_q <= disp_bcd_d;
         disp_cnt_q <= disp_cnt_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
